// File: rtl/dpd_poly_apply.sv
// dpd_poly_apply
//   Memory-less DPD polynomial: forms the complex gain g = sum_k c_k*|x|^k
//   from the magnitude basis |x|^0..|x|^4 and applies it to the time-aligned
//   input sample, y = x*g. Coefficients live in a shadow bank and become
//   active only on an atomic swap.
//
//   Streaming: one sample per clock in, one per clock out, no backpressure.
//   out_valid only reports that the pipeline has filled since reset.
//
// Ports
//   clk, reset_n              clock, asynchronous active-low reset
//   sig_in_i/q   [19:0]  in   input sample, signed Q1.19
//   mag_0..mag_4 [19:0]  in   basis |x|^k, unsigned Q1.19, lag sig_in by X_ALIGN
//   coef_wr_en, coef_addr     shadow-bank write strobe / index (5..7 ignored)
//   coef_wr_i/q  [COEF_W-1:0] coefficient, signed Q2.15
//   coef_swap                 shadow -> active copy pulse
//   bypass                    pass aligned input through unchanged
//   sat_clr                   clear sticky saturation flag
//   sig_out_i/q  [19:0]  out  predistorted sample, signed Q1.19
//   out_valid, coef_pending, sat_flag   status
module dpd_poly_apply #(
  parameter int X_ALIGN = 6,
  parameter int COEF_W  = 18
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic signed [19:0]       sig_in_i,
  input  logic signed [19:0]       sig_in_q,
  input  logic        [19:0]       mag_0,
  input  logic        [19:0]       mag_1,
  input  logic        [19:0]       mag_2,
  input  logic        [19:0]       mag_3,
  input  logic        [19:0]       mag_4,
  input  logic                     coef_wr_en,
  input  logic        [2:0]        coef_addr,
  input  logic signed [COEF_W-1:0] coef_wr_i,
  input  logic signed [COEF_W-1:0] coef_wr_q,
  input  logic                     coef_swap,
  input  logic                     bypass,
  input  logic                     sat_clr,
  output logic signed [19:0]       sig_out_i,
  output logic signed [19:0]       sig_out_q,
  output logic                     out_valid,
  output logic                     coef_pending,
  output logic                     sat_flag
);

  localparam int XW   = 20;
  localparam int NB   = 5;
  localparam int PW   = COEF_W + XW + 1;   // mag*coef product
  localparam int SW   = PW + 3;            // sum of five products
  localparam int MW   = XW + COEF_W;       // x*g product
  localparam int YW   = MW + 1;            // complex-multiply sum
  localparam int DL   = X_ALIGN + 2;       // x delay to meet g at S3
  localparam int FILL = X_ALIGN + 5;
  localparam int CW   = $clog2(FILL + 1);

  localparam logic signed [COEF_W-1:0] C_ONE = COEF_W'(2 ** (COEF_W - 3));
  localparam logic signed [SW-1:0] G_RND = SW'(2 ** (XW - 2));
  localparam logic signed [SW-1:0] G_MAX = SW'(2 ** (COEF_W - 1) - 1);
  localparam logic signed [SW-1:0] G_MIN = SW'(-(2 ** (COEF_W - 1)));
  localparam logic signed [YW-1:0] Y_RND = YW'(2 ** (COEF_W - 4));
  localparam logic signed [YW-1:0] O_MAX = YW'(2 ** (XW - 1) - 1);
  localparam logic signed [YW-1:0] O_MIN = YW'(-(2 ** (XW - 1)));

  // ---------------- coefficient banks ----------------
  logic signed [COEF_W-1:0] sh_i  [NB];
  logic signed [COEF_W-1:0] sh_q  [NB];
  logic signed [COEF_W-1:0] act_i [NB];
  logic signed [COEF_W-1:0] act_q [NB];
  logic                     wr_hit;

  assign wr_hit = coef_wr_en && (coef_addr < 3'd5);

  // Swap reads the shadow through NBA semantics, so a same-edge write is
  // not visible to the copy and leaves coef_pending set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NB; k++) begin
        sh_i[k]  <= (k == 0) ? C_ONE : '0;
        sh_q[k]  <= '0;
        act_i[k] <= (k == 0) ? C_ONE : '0;
        act_q[k] <= '0;
      end
      coef_pending <= 1'b0;
    end else begin
      if (coef_swap) begin
        for (int k = 0; k < NB; k++) begin
          act_i[k] <= sh_i[k];
          act_q[k] <= sh_q[k];
        end
      end
      if (wr_hit) begin
        sh_i[coef_addr] <= coef_wr_i;
        sh_q[coef_addr] <= coef_wr_q;
      end
      if (wr_hit)         coef_pending <= 1'b1;
      else if (coef_swap) coef_pending <= 1'b0;
    end
  end

  // ---------------- S1: basis products ----------------
  logic        [XW-1:0] mag [NB];
  logic signed [PW-1:0] p_i [NB];
  logic signed [PW-1:0] p_q [NB];

  assign mag = '{mag_0, mag_1, mag_2, mag_3, mag_4};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NB; k++) begin
        p_i[k] <= '0;
        p_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NB; k++) begin
        p_i[k] <= $signed(PW'(mag[k])) * PW'(act_i[k]);
        p_q[k] <= $signed(PW'(mag[k])) * PW'(act_q[k]);
      end
    end
  end

  // ---------------- S2: gain sum, round, saturate ----------------
  logic signed [SW-1:0]     sum_i, sum_q, gsh_i, gsh_q;
  logic signed [COEF_W-1:0] gn_i, gn_q, g_i, g_q;
  logic                     g_clamp;

  always_comb begin
    sum_i = '0;
    sum_q = '0;
    for (int k = 0; k < NB; k++) begin
      sum_i = sum_i + SW'(p_i[k]);
      sum_q = sum_q + SW'(p_q[k]);
    end
    // Q1.19 * Q2.15 -> drop 19 fraction bits with round-half-up.
    gsh_i   = (sum_i + G_RND) >>> (XW - 1);
    gsh_q   = (sum_q + G_RND) >>> (XW - 1);
    g_clamp = 1'b0;
    gn_i    = gsh_i[COEF_W-1:0];
    gn_q    = gsh_q[COEF_W-1:0];
    if (gsh_i > G_MAX) begin
      gn_i = G_MAX[COEF_W-1:0]; g_clamp = 1'b1;
    end else if (gsh_i < G_MIN) begin
      gn_i = G_MIN[COEF_W-1:0]; g_clamp = 1'b1;
    end
    if (gsh_q > G_MAX) begin
      gn_q = G_MAX[COEF_W-1:0]; g_clamp = 1'b1;
    end else if (gsh_q < G_MIN) begin
      gn_q = G_MIN[COEF_W-1:0]; g_clamp = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      g_i <= '0;
      g_q <= '0;
    end else begin
      g_i <= gn_i;
      g_q <= gn_q;
    end
  end

  // ---------------- x delay line ----------------
  logic signed [XW-1:0] xd_i [DL];
  logic signed [XW-1:0] xd_q [DL];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < DL; k++) begin
        xd_i[k] <= '0;
        xd_q[k] <= '0;
      end
    end else begin
      xd_i[0] <= sig_in_i;
      xd_q[0] <= sig_in_q;
      for (int k = 1; k < DL; k++) begin
        xd_i[k] <= xd_i[k-1];
        xd_q[k] <= xd_q[k-1];
      end
    end
  end

  // ---------------- S3 / S4: complex multiply ----------------
  logic signed [MW-1:0] m_ii, m_qq, m_iq, m_qi;
  logic signed [YW-1:0] y_i, y_q;
  logic signed [XW-1:0] xb3_i, xb3_q, xb4_i, xb4_q;
  logic                 byp3, byp4;

  // bypass is captured alongside the sample entering S3 so a toggle
  // lands exactly on one sample boundary.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_ii <= '0; m_qq <= '0; m_iq <= '0; m_qi <= '0;
      y_i  <= '0; y_q  <= '0;
      xb3_i <= '0; xb3_q <= '0; xb4_i <= '0; xb4_q <= '0;
      byp3 <= 1'b0; byp4 <= 1'b0;
    end else begin
      m_ii  <= MW'(xd_i[DL-1]) * MW'(g_i);
      m_qq  <= MW'(xd_q[DL-1]) * MW'(g_q);
      m_iq  <= MW'(xd_i[DL-1]) * MW'(g_q);
      m_qi  <= MW'(xd_q[DL-1]) * MW'(g_i);
      xb3_i <= xd_i[DL-1];
      xb3_q <= xd_q[DL-1];
      byp3  <= bypass;
      y_i   <= YW'(m_ii) - YW'(m_qq);
      y_q   <= YW'(m_iq) + YW'(m_qi);
      xb4_i <= xb3_i;
      xb4_q <= xb3_q;
      byp4  <= byp3;
    end
  end

  // ---------------- S5: round, saturate, output ----------------
  logic signed [YW-1:0] ysh_i, ysh_q;
  logic signed [XW-1:0] yo_i, yo_q;
  logic                 y_clamp;

  always_comb begin
    ysh_i   = (y_i + Y_RND) >>> (COEF_W - 3);
    ysh_q   = (y_q + Y_RND) >>> (COEF_W - 3);
    y_clamp = 1'b0;
    yo_i    = ysh_i[XW-1:0];
    yo_q    = ysh_q[XW-1:0];
    if (ysh_i > O_MAX) begin
      yo_i = O_MAX[XW-1:0]; y_clamp = 1'b1;
    end else if (ysh_i < O_MIN) begin
      yo_i = O_MIN[XW-1:0]; y_clamp = 1'b1;
    end
    if (ysh_q > O_MAX) begin
      yo_q = O_MAX[XW-1:0]; y_clamp = 1'b1;
    end else if (ysh_q < O_MIN) begin
      yo_q = O_MIN[XW-1:0]; y_clamp = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sig_out_i <= '0;
      sig_out_q <= '0;
      sat_flag  <= 1'b0;
    end else begin
      sig_out_i <= byp4 ? xb4_i : yo_i;
      sig_out_q <= byp4 ? xb4_q : yo_q;
      // A clamp in a bypassed sample is discarded, so it does not flag.
      if (g_clamp || (y_clamp && !byp4)) sat_flag <= 1'b1;
      else if (sat_clr)                   sat_flag <= 1'b0;
    end
  end

  // ---------------- fill counter ----------------
  logic [CW-1:0] fill_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fill_cnt  <= '0;
      out_valid <= 1'b0;
    end else if (!out_valid) begin
      fill_cnt <= fill_cnt + CW'(1);
      if (fill_cnt == CW'(FILL - 1)) out_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dpd_poly_apply.sv
// Bench for dpd_poly_apply: directed literal checks plus a randomized stream
// compared every cycle against a sample-history reference model.
module tb_dpd_poly_apply;
  localparam int X_ALIGN = 6;
  localparam int FILL    = X_ALIGN + 5;
  localparam int NMAX    = 8192;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic signed [19:0] sig_in_i = '0, sig_in_q = '0;
  logic        [19:0] mag_0 = '0, mag_1 = '0, mag_2 = '0, mag_3 = '0, mag_4 = '0;
  logic               coef_wr_en = 1'b0;
  logic        [2:0]  coef_addr = '0;
  logic signed [17:0] coef_wr_i = '0, coef_wr_q = '0;
  logic               coef_swap = 1'b0, bypass = 1'b0, sat_clr = 1'b0;
  logic signed [19:0] sig_out_i, sig_out_q;
  logic               out_valid, coef_pending, sat_flag;

  dpd_poly_apply #(.X_ALIGN(X_ALIGN), .COEF_W(18)) dut (
    .clk(clk), .reset_n(reset_n),
    .sig_in_i(sig_in_i), .sig_in_q(sig_in_q),
    .mag_0(mag_0), .mag_1(mag_1), .mag_2(mag_2), .mag_3(mag_3), .mag_4(mag_4),
    .coef_wr_en(coef_wr_en), .coef_addr(coef_addr),
    .coef_wr_i(coef_wr_i), .coef_wr_q(coef_wr_q),
    .coef_swap(coef_swap), .bypass(bypass), .sat_clr(sat_clr),
    .sig_out_i(sig_out_i), .sig_out_q(sig_out_q),
    .out_valid(out_valid), .coef_pending(coef_pending), .sat_flag(sat_flag)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0d want=%0d", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Per-edge history of what the DUT sampled; outputs are derived from the
  // sample that entered the pipe 4 edges earlier, x from X_ALIGN before that.
  int  hx_i [NMAX];
  int  hx_q [NMAX];
  int  hm   [NMAX][5];
  int  ha_i [NMAX][5];
  int  ha_q [NMAX][5];
  bit  hb   [NMAX];
  int  sh_i [5], sh_q [5], ac_i [5], ac_q [5];
  bit  pend_m = 1'b0, sat_m = 1'b0;
  int  ecnt = 0, e0 = 0;
  logic [42:0] exp_q[$];

  function automatic longint sat_to(input longint v, input longint lim, output bit c);
    c = 1'b0;
    if (v > lim - 1) begin c = 1'b1; return lim - 1; end
    if (v < -lim)    begin c = 1'b1; return -lim; end
    return v;
  endfunction

  // gain for the sample that entered at edge s, using the bank active before it
  function automatic void g_of(input int s, output longint gi, output longint gq, output bit gc);
    longint si, sq;
    bit ci, cq;
    gi = 0; gq = 0; gc = 1'b0;
    if (s < e0 || s < 1) return;
    si = 0; sq = 0;
    for (int k = 0; k < 5; k++) begin
      si += longint'(hm[s][k]) * ha_i[s-1][k];
      sq += longint'(hm[s][k]) * ha_q[s-1][k];
    end
    gi = sat_to((si + 262144) >>> 19, 131072, ci);
    gq = sat_to((sq + 262144) >>> 19, 131072, cq);
    gc = ci | cq;
  endfunction

  function automatic void out_at(input int e, output longint oi, output longint oq, output bit yc);
    longint gi, gq, xi, xq;
    bit gc, byp, ci, cq;
    int s, xs;
    s  = e - 4;
    xs = s - X_ALIGN;
    g_of(s, gi, gq, gc);
    xi = 0; xq = 0;
    if (xs >= e0 && xs >= 0) begin xi = hx_i[xs]; xq = hx_q[xs]; end
    byp = (e - 2 >= e0 && e - 2 >= 0) ? hb[e-2] : 1'b0;
    yc = 1'b0;
    if (byp) begin
      oi = xi; oq = xq;
    end else begin
      oi = sat_to((xi * gi - xq * gq + 16384) >>> 15, 524288, ci);
      oq = sat_to((xi * gq + xq * gi + 16384) >>> 15, 524288, cq);
      yc = ci | cq;
    end
  endfunction

  always @(posedge clk) begin
    int e;
    longint oi, oq, gi, gq;
    bit yc, gc, wr_hit, valid;
    e = ecnt;
    ecnt++;
    if (e >= NMAX) begin
      $display("FAIL model_depth t=%0t got=%0d want=%0d", $time, e, NMAX);
      $fatal(1, "history exhausted");
    end
    if (!reset_n) begin
      hx_i[e] = 0; hx_q[e] = 0; hb[e] = 1'b0;
      for (int k = 0; k < 5; k++) begin
        hm[e][k] = 0;
        sh_i[k] = (k == 0) ? 32768 : 0; sh_q[k] = 0;
        ac_i[k] = (k == 0) ? 32768 : 0; ac_q[k] = 0;
        ha_i[e][k] = ac_i[k]; ha_q[e][k] = 0;
      end
      pend_m = 1'b0; sat_m = 1'b0; e0 = e + 1;
      exp_q.delete();
    end else begin
      hx_i[e] = sig_in_i; hx_q[e] = sig_in_q;
      hm[e][0] = mag_0; hm[e][1] = mag_1; hm[e][2] = mag_2;
      hm[e][3] = mag_3; hm[e][4] = mag_4;
      hb[e] = bypass;
      wr_hit = coef_wr_en && (coef_addr < 5);
      if (coef_swap)
        for (int k = 0; k < 5; k++) begin ac_i[k] = sh_i[k]; ac_q[k] = sh_q[k]; end
      if (wr_hit) begin sh_i[coef_addr] = coef_wr_i; sh_q[coef_addr] = coef_wr_q; end
      if (wr_hit) pend_m = 1'b1;
      else if (coef_swap) pend_m = 1'b0;
      for (int k = 0; k < 5; k++) begin ha_i[e][k] = ac_i[k]; ha_q[e][k] = ac_q[k]; end
      out_at(e, oi, oq, yc);
      g_of(e - 1, gi, gq, gc);
      if (gc || yc) sat_m = 1'b1;
      else if (sat_clr) sat_m = 1'b0;
      valid = (e - e0 + 1) >= FILL;
      exp_q.push_back({oi[19:0], oq[19:0], valid, pend_m, sat_m});
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    logic [42:0] ent;
    if (reset_n && exp_q.size() > 0) begin
      ent = exp_q.pop_front();
      chk("sig_out_i", sig_out_i, $signed(ent[42:23]));
      chk("sig_out_q", sig_out_q, $signed(ent[22:3]));
      chk("out_valid", out_valid, ent[2]);
      chk("coef_pending", coef_pending, ent[1]);
      chk("sat_flag", sat_flag, ent[0]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_x(input int i, input int q);
    sig_in_i = 20'(i); sig_in_q = 20'(q);
  endtask

  task automatic set_mag(input int a, input int b, input int c, input int d, input int f);
    mag_0 = 20'(a); mag_1 = 20'(b); mag_2 = 20'(c); mag_3 = 20'(d); mag_4 = 20'(f);
  endtask

  task automatic wr_coef(input int addr, input int ci, input int cq, input bit sw);
    @(negedge clk);
    coef_wr_en = 1'b1; coef_addr = 3'(addr);
    coef_wr_i = 18'(ci); coef_wr_q = 18'(cq); coef_swap = sw;
    @(negedge clk);
    coef_wr_en = 1'b0; coef_swap = 1'b0;
  endtask

  task automatic do_swap();
    @(negedge clk); coef_swap = 1'b1;
    @(negedge clk); coef_swap = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk); sat_clr = 1'b1;
    @(negedge clk); sat_clr = 1'b0;
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic assert_reset();
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_out_i", sig_out_i, 0);
    chk("rst_out_q", sig_out_q, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_pending", coef_pending, 0);
    chk("rst_sat", sat_flag, 0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    #2 reset_n = 1'b1;
  endtask

  // identity check after reset release: valid rises exactly at FILL edges
  task automatic fill_identity();
    set_x(100000, -50000);
    set_mag(524287, 0, 0, 0, 0);
    release_reset();
    for (int i = 1; i <= FILL; i++) begin
      @(negedge clk);
      chk("fill_valid", out_valid, (i == FILL) ? 1 : 0);
    end
    chk("ident_i", sig_out_i, 100000);
    chk("ident_q", sig_out_q, -50000);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    hold(3);
    chk("init_out_i", sig_out_i, 0);
    chk("init_valid", out_valid, 0);
    chk("init_pending", coef_pending, 0);
    chk("init_sat", sat_flag, 0);

    // identity after reset
    fill_identity();

    // c1 = j*1.0, |x| = 0.5 -> gain 1 + 0.5j
    wr_coef(1, 0, 32768, 1'b0);
    chk("pend_after_wr", coef_pending, 1);
    do_swap();
    chk("pend_after_swap", coef_pending, 0);
    set_mag(524287, 262144, 0, 0, 0);
    set_x(100000, 0);
    hold(16);
    chk("c1_out_i", sig_out_i, 100000);
    chk("c1_out_q", sig_out_q, 50000);

    // large gain -> output clamp, sticky flag and clear
    wr_coef(1, 0, 0, 1'b0);
    wr_coef(0, 131071, 0, 1'b0);
    do_swap();
    set_mag(524287, 0, 0, 0, 0);
    set_x(400000, 0);
    hold(16);
    chk("clamp_out_i", sig_out_i, 524287);
    chk("clamp_out_q", sig_out_q, 0);
    chk("clamp_sat", sat_flag, 1);
    set_x(10000, 0);
    hold(16);
    chk("gain4_out_i", sig_out_i, 40000);
    pulse_clr();
    chk("sat_cleared", sat_flag, 0);
    set_x(400000, 0);
    hold(16);
    pulse_clr();
    chk("sat_set_wins", sat_flag, 1);

    // write + swap in the same cycle: swap takes the old shadow
    wr_coef(0, 32768, 0, 1'b0);
    do_swap();
    set_x(100000, 0);
    hold(16);
    chk("restore_out_i", sig_out_i, 100000);
    wr_coef(0, 16384, 0, 1'b1);
    chk("wr_swap_pend", coef_pending, 1);
    hold(16);
    chk("wr_swap_out_i", sig_out_i, 100000);
    do_swap();
    chk("second_swap_pend", coef_pending, 0);
    hold(16);
    chk("half_out_i", sig_out_i, 50000);

    // bypass with zero gain, then toggle mid-stream
    wr_coef(0, 0, 0, 1'b0);
    do_swap();
    bypass = 1'b1;
    set_x(123456, -7890);
    hold(16);
    chk("byp_out_i", sig_out_i, 123456);
    chk("byp_out_q", sig_out_q, -7890);
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      set_x(n * 1000, -n * 500);
      if (n == 12) bypass = 1'b0;
    end
    hold(16);
    chk("zero_gain_i", sig_out_i, 0);
    chk("zero_gain_q", sig_out_q, 0);
    pulse_clr();
    chk("sat_clear2", sat_flag, 0);

    // reset while streaming with non-identity coefficients
    wr_coef(0, 16384, 0, 1'b0);
    do_swap();
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      set_x(int'($urandom_range(0, 400000)) - 200000, int'($urandom_range(0, 400000)) - 200000);
    end
    assert_reset();
    hold(2);
    fill_identity();
    chk("post_rst_pend", coef_pending, 0);

    // randomized stream
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      set_x(int'($urandom_range(0, 1048575)) - 524288, int'($urandom_range(0, 1048575)) - 524288);
      set_mag($urandom_range(0, 1048575), $urandom_range(0, 1048575), $urandom_range(0, 1048575),
              $urandom_range(0, 1048575), $urandom_range(0, 1048575));
      coef_wr_en = ($urandom_range(0, 7) == 0);
      coef_addr  = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) begin
        coef_wr_i = 18'($urandom_range(0, 262143));
        coef_wr_q = 18'($urandom_range(0, 262143));
      end else begin
        coef_wr_i = 18'(int'($urandom_range(0, 80000)) - 40000);
        coef_wr_q = 18'(int'($urandom_range(0, 80000)) - 40000);
      end
      coef_swap = ($urandom_range(0, 15) == 0);
      sat_clr   = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 31) == 0) bypass = ~bypass;
      if (n == 1000) begin
        coef_wr_en = 1'b0; coef_swap = 1'b0; sat_clr = 1'b0;
        assert_reset();
        hold(2);
        release_reset();
      end
    end
    @(negedge clk);
    coef_wr_en = 1'b0; coef_swap = 1'b0; sat_clr = 1'b0; bypass = 1'b0;
    hold(FILL + 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
